// File: rtl/sisc_pkg.sv
// sisc_pkg: shared encodings for the SISC memory port arbiter (FSM states, access owner)
package sisc_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;
endpackage

// File: rtl/arb_streak_cnt.sv
// arb_streak_cnt: saturating count of load/store grants made while a fetch waits
// ports: clk, rst_f (async active-low), ls_grant, if_pending, if_grant in; at_limit out
module arb_streak_cnt #(
    parameter int MAX_STREAK = 4
) (
    input  logic clk,
    input  logic rst_f,
    input  logic ls_grant,
    input  logic if_pending,
    input  logic if_grant,
    output logic at_limit
);
    localparam int CW = $clog2(MAX_STREAK + 1);
    localparam logic [CW-1:0] LIM = CW'(MAX_STREAK);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f)
            cnt <= '0;
        else if (if_grant || (ls_grant && !if_pending))
            cnt <= '0;
        else if (ls_grant && cnt != LIM)
            cnt <= cnt + 1'b1;
    end
    assign at_limit = cnt == LIM;
endmodule

// File: rtl/mem_port_arb.sv
// mem_port_arb: fetch vs load/store arbiter and sequencer for a single-port memory
// ports: clk, rst_f (async active-low); if_req/if_addr in, if_done/if_rdata out;
//        ls_req/ls_we/ls_addr/ls_wdata in, ls_done/ls_rdata out;
//        mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in; busy out
module mem_port_arb
    import sisc_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int MAX_STREAK = 4,
    parameter int AW         = 16
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [31:0]   if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [31:0]   ls_wdata,
    output logic          ls_done,
    output logic [31:0]   ls_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);
    localparam int LW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    state_t        state, state_d;
    owner_t        own;
    logic          we_q;
    logic [LW-1:0] lat;
    logic          at_limit, grant_ls, grant_if, cap;
    arb_streak_cnt #(.MAX_STREAK(MAX_STREAK)) u_streak (
        .clk       (clk),
        .rst_f     (rst_f),
        .ls_grant  (grant_ls),
        .if_pending(if_req),
        .if_grant  (grant_if),
        .at_limit  (at_limit)
    );
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f)
            state <= ST_IDLE;
        else
            state <= state_d;
    end
    always_comb begin
        grant_ls = state == ST_IDLE && ls_req && !(if_req && at_limit);
        grant_if = state == ST_IDLE && if_req && !grant_ls;
        cap      = state == ST_WAIT && lat == '0;
        state_d  = state;
        case (state)
            ST_IDLE:  state_d = (grant_ls || grant_if) ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = cap ? ST_DONE : ST_WAIT;
            default:  state_d = ST_IDLE;
        endcase
    end
    // mem_* are loaded on the grant edge so they appear exactly in the ISSUE cycle;
    // mem_addr/mem_wdata double as the address/data latches.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            own       <= OWN_IF;
            we_q      <= 1'b0;
            lat       <= '0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            ls_done   <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
        end else begin
            busy      <= state_d != ST_IDLE;
            mem_en    <= grant_ls || grant_if;
            mem_we    <= grant_ls && ls_we;
            own       <= grant_ls ? OWN_LS : grant_if ? OWN_IF : own;
            we_q      <= (grant_ls || grant_if) ? grant_ls && ls_we : we_q;
            mem_addr  <= grant_ls ? ls_addr : grant_if ? if_addr : mem_addr;
            mem_wdata <= grant_ls ? ls_wdata : mem_wdata;
            lat       <= state == ST_ISSUE ? LW'(MEM_LAT - 1) : (state == ST_WAIT && lat != '0) ? lat - 1'b1 : lat;
            if_done   <= cap && own == OWN_IF;
            ls_done   <= cap && own == OWN_LS;
            if_rdata  <= (cap && own == OWN_IF) ? mem_rdata : if_rdata;
            ls_rdata  <= (cap && own == OWN_LS && !we_q) ? mem_rdata : ls_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: directed self-checking bench for mem_port_arb (MEM_LAT=2 and MEM_LAT=1 instances)
module tb_mem_port_arb;
    logic        clk = 1'b0;
    logic        rst_f;
    logic        if_req, ls_req, ls_we;
    logic [15:0] if_addr, ls_addr;
    logic [31:0] ls_wdata, mem_rdata;
    logic        if_done, ls_done, mem_en, mem_we, busy;
    logic [31:0] if_rdata, ls_rdata, mem_wdata;
    logic [15:0] mem_addr;
    logic        if_req1, ls_req1, ls_we1;
    logic [15:0] if_addr1, ls_addr1;
    logic [31:0] ls_wdata1, mem_rdata1;
    logic        if_done1, ls_done1, mem_en1, mem_we1, busy1;
    logic [31:0] if_rdata1, ls_rdata1, mem_wdata1;
    logic [15:0] mem_addr1;
    logic [31:0] p0a = '0, p0b = '0, p1a = '0;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arb #(.MEM_LAT(2), .MAX_STREAK(4), .AW(16)) u_dut (
        .clk(clk), .rst_f(rst_f),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arb #(.MEM_LAT(1), .MAX_STREAK(4), .AW(16)) u_dut1 (
        .clk(clk), .rst_f(rst_f),
        .if_req(if_req1), .if_addr(if_addr1), .if_done(if_done1), .if_rdata(if_rdata1),
        .ls_req(ls_req1), .ls_we(ls_we1), .ls_addr(ls_addr1), .ls_wdata(ls_wdata1),
        .ls_done(ls_done1), .ls_rdata(ls_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    function automatic logic [31:0] mdata(input logic [15:0] a);
        return a == 16'h0010 ? 32'h1234_5678 : {16'hC0DE, a};
    endfunction

    // memory model: data is valid only in the cycle MEM_LAT after mem_en, zero otherwise
    always @(posedge clk) begin
        p0a <= mem_en ? mdata(mem_addr) : '0;
        p0b <= p0a;
        p1a <= mem_en1 ? mdata(mem_addr1) : '0;
    end
    assign mem_rdata  = p0b;
    assign mem_rdata1 = p1a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] order [10];
        int t;
        order = '{16'h0B00, 16'h0B00, 16'h0B00, 16'h0B00, 16'h0A00,
                  16'h0B00, 16'h0B00, 16'h0B00, 16'h0B00, 16'h0A00};
        rst_f = 1'b0;
        if_req = 0; ls_req = 0; ls_we = 0; if_addr = '0; ls_addr = '0; ls_wdata = '0;
        if_req1 = 0; ls_req1 = 0; ls_we1 = 0; if_addr1 = '0; ls_addr1 = '0; ls_wdata1 = '0;
        #12;
        check("rst_flags", {27'd0, mem_en, mem_we, if_done, ls_done, busy}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_ls_rdata", ls_rdata, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk) rst_f = 1'b1;

        // single fetch
        @(negedge clk) begin if_req = 1; if_addr = 16'h0010; end
        step(1);
        check("f_mem_en", {31'd0, mem_en}, 32'd1);
        check("f_mem_addr", {16'd0, mem_addr}, 32'h0010);
        check("f_mem_we", {31'd0, mem_we}, 32'd0);
        step(2);
        check("f_done_early", {31'd0, if_done}, 32'd0);
        step(1);
        check("f_done", {31'd0, if_done}, 32'd1);
        check("f_rdata", if_rdata, 32'h1234_5678);
        if_req = 0;
        step(1);
        check("f_busy_low", {30'd0, busy, if_done}, 32'd0);

        // simultaneous: ls wins, fetch follows
        @(negedge clk) begin if_req = 1; if_addr = 16'h0044; ls_req = 1; ls_we = 0; ls_addr = 16'h0200; end
        step(1);
        check("s_ls_first", {15'd0, mem_en, mem_addr}, {15'd0, 1'b1, 16'h0200});
        step(3);
        check("s_ls_done", {30'd0, ls_done, if_done}, 32'd2);
        check("s_ls_rdata", ls_rdata, 32'hC0DE_0200);
        ls_req = 0;
        step(2);
        check("s_if_issue", {15'd0, mem_en, mem_addr}, {15'd0, 1'b1, 16'h0044});
        step(3);
        check("s_if_done", {31'd0, if_done}, 32'd1);
        check("s_if_rdata", if_rdata, 32'hC0DE_0044);
        if_req = 0;
        step(1);

        // store
        @(negedge clk) begin ls_req = 1; ls_we = 1; ls_addr = 16'h0300; ls_wdata = 32'hDEAD_BEEF; end
        step(1);
        check("st_we_addr", {14'd0, mem_en, mem_we, mem_addr}, {14'd0, 2'b11, 16'h0300});
        check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        step(1);
        check("st_we_drop", {30'd0, mem_en, mem_we}, 32'd0);
        step(2);
        check("st_done", {31'd0, ls_done}, 32'd1);
        check("st_rdata_kept", ls_rdata, 32'hC0DE_0200);
        ls_req = 0; ls_we = 0;
        step(1);
        check("st_done_once", {31'd0, ls_done}, 32'd0);

        // starvation: both held, streak limit forces a fetch every fifth grant
        @(negedge clk) begin if_req = 1; if_addr = 16'h0A00; ls_req = 1; ls_addr = 16'h0B00; end
        for (int g = 0; g < 10; g++) begin
            t = 0;
            do begin step(1); t++; end while (!mem_en && t < 10);
            check($sformatf("grant%0d", g), {15'd0, mem_en, mem_addr}, {15'd0, 1'b1, order[g]});
        end
        if_req = 0; ls_req = 0;
        step(3);
        check("drop_if_done", {31'd0, if_done}, 32'd1);
        check("drop_if_rdata", if_rdata, 32'hC0DE_0A00);
        step(1);

        // reset in the WAIT cycle of a load
        @(negedge clk) begin ls_req = 1; ls_addr = 16'h0500; end
        step(1);
        check("r_issue", {31'd0, mem_en}, 32'd1);
        step(1);
        #2 rst_f = 1'b0;
        #1;
        check("r_flags", {27'd0, mem_en, mem_we, if_done, ls_done, busy}, 32'd0);
        check("r_ls_rdata", ls_rdata, 32'd0);
        check("r_if_rdata", if_rdata, 32'd0);
        check("r_mem_addr", {16'd0, mem_addr}, 32'd0);
        @(negedge clk);
        @(negedge clk) rst_f = 1'b1;
        step(1);
        check("r_rearb", {15'd0, mem_en, mem_addr}, {15'd0, 1'b1, 16'h0500});
        step(2);
        check("r_no_done", {31'd0, ls_done}, 32'd0);
        step(1);
        check("r_done", {31'd0, ls_done}, 32'd1);
        check("r_rdata", ls_rdata, 32'hC0DE_0500);
        ls_req = 0;
        step(1);

        // MEM_LAT=1 fetch stream
        @(negedge clk) begin if_req1 = 1; if_addr1 = 16'h0700; end
        t = 0;
        do begin step(1); t++; end while (!if_done1 && t < 10);
        check("l1_first", t, 32'd3);
        check("l1_rdata0", if_rdata1, 32'hC0DE_0700);
        for (int k = 0; k < 3; k++) begin
            t = 0;
            do begin step(1); t++; end while (!if_done1 && t < 10);
            check($sformatf("l1_period%0d", k), t, 32'd4);
            check($sformatf("l1_rdata%0d", k + 1), if_rdata1, 32'hC0DE_0700);
        end
        if_req1 = 0;
        step(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
